// File: rtl/ifetch_buffer_if.sv
// Fetch-stage bus bundle: PC-register handshake, instruction-memory port and
// decode handshake. The fetch buffer uses the master view. The PC register,
// memory and decode side use the slave view.
interface ifetch_buffer_if;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  pc_in, flush, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    output pc_ena, imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output pc_in, flush, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    input  pc_ena, imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer. It issues in-order fetches at the current PC and
// queues the returned words with their PC in a DEPTH-entry circular buffer.
// Buffered words are handed to decode under valid/ready. A flush throws away
// everything buffered and discards responses that are still in flight.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic             clk,
  input logic             rst,
  ifetch_buffer_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    alloc_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [CW-1:0]    used_q, used_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic             seen_q;
  logic [31:0]      last_inst_q;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      word_mem [DEPTH];

  logic req, accept, head_valid, pop, fill;

  // Handshake decode for this cycle; flush suppresses every transfer.
  always_comb begin
    req        = (state_q == S_RUN) && !bus.flush && (used_q < CW'(DEPTH));
    accept     = req && bus.imem_ready;
    head_valid = filled_q[rd_ptr_q];
    pop        = head_valid && bus.inst_ready && !bus.flush;
    fill       = (state_q == S_RUN) && !bus.flush && bus.imem_rvalid;
  end

  // Next occupancy, stale-response count, filled bits and state.
  always_comb begin
    // NOTE: every target gets a default first so no path through this block infers a latch.
    used_d     = used_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    state_d    = state_q;
    if (bus.flush) begin
      used_d     = '0;
      inflight_d = '0;
      filled_d   = '0;
      // Drain already under way: nothing new is in flight, so only this cycle's response counts.
      if (state_q == S_DRAIN) begin
        drop_d = (bus.imem_rvalid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
      end else begin
        drop_d = (bus.imem_rvalid && inflight_q != '0) ? inflight_q - CW'(1) : inflight_q;
      end
      state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
    end else begin
      case (state_q)
        S_INIT:  state_d = S_RUN;
        S_DRAIN: begin
          if (bus.imem_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
          if (drop_d == '0) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
      if (accept) filled_d[alloc_ptr_q] = 1'b0;
      if (fill)   filled_d[fill_ptr_q]  = 1'b1;
      if (pop)    filled_d[rd_ptr_q]    = 1'b0;
      used_d     = used_q + CW'(accept) - CW'(pop);
      inflight_d = inflight_q + CW'(accept) - CW'(fill && inflight_q != '0);
    end
  end

  // Control state: FSM, pointers, counters, filled bits and held head word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      inflight_q  <= '0;
      drop_q      <= '0;
      filled_q    <= '0;
      seen_q      <= 1'b0;
      last_inst_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values of the others.
      state_q    <= state_d;
      used_q     <= used_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
      if (bus.flush) begin
        alloc_ptr_q <= '0;
        fill_ptr_q  <= '0;
        rd_ptr_q    <= '0;
      end else begin
        if (accept) alloc_ptr_q <= alloc_ptr_q + PW'(1);
        if (fill)   fill_ptr_q  <= fill_ptr_q + PW'(1);
        if (pop)    rd_ptr_q    <= rd_ptr_q + PW'(1);
      end
      if (accept)     seen_q      <= 1'b1;
      if (head_valid) last_inst_q <= word_mem[rd_ptr_q];
    end
  end

  // Slot payload storage, written on accept (pc) and on response (word).
  // NOTE: payloads are qualified by filled/seen flags, so the storage itself carries no reset.
  always_ff @(posedge clk) begin
    if (accept) pc_mem[alloc_ptr_q]  <= bus.pc_in;
    if (fill)   word_mem[fill_ptr_q] <= bus.imem_rdata;
  end

  assign bus.imem_req   = req;
  assign bus.pc_ena     = accept;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? word_mem[rd_ptr_q] : last_inst_q;
  assign bus.inst_pc    = seen_q ? pc_mem[rd_ptr_q] : RESET_PC;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer. A queue-based model of the fetch pipeline is compared
// against the DUT on every falling edge. The model tracks fetches in flight,
// buffered words and the count of stale responses. Directed scenarios add
// hand-computed literal expectations. The PC register and the instruction
// memory are emulated around the DUT.
module tb_ifetch_buffer;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;

  ifetch_buffer_if bus ();

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  // Environment: memory with configurable latency, and the PC register.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          mem_lat   = 1;
  int          cyc       = 0;
  logic [31:0] pc_nxt    = RESET_PC;
  logic        rv_nxt    = 1'b0;
  logic [31:0] rd_nxt    = '0;
  logic [31:0] flush_tgt = '0;

  // Reference model.
  typedef enum {P_INIT, P_RUN, P_DRAIN} phase_e;
  phase_e      m_phase = P_INIT;
  logic [31:0] m_inflight[$];
  logic [31:0] m_buf[$];
  int          m_drop = 0;
  bit          m_seen = 1'b0;

  // Compare process: check outputs mid-cycle, then advance model and environment.
  always @(negedge clk) begin
    logic  exp_req;
    int    n;
    mreq_t r;
    if (!rst) begin
      check("rst_imem_req", bus.imem_req, 1'b0);
      check("rst_pc_ena", bus.pc_ena, 1'b0);
      check("rst_inst_valid", bus.inst_valid, 1'b0);
      check("rst_inst", bus.inst, 32'h0);
      check("rst_inst_pc", bus.inst_pc, RESET_PC);
      m_phase = P_INIT;
      m_inflight.delete();
      m_buf.delete();
      m_drop = 0;
      m_seen = 1'b0;
      mem_q.delete();
      pc_nxt = RESET_PC;
      rv_nxt = 1'b0;
      rd_nxt = '0;
    end else begin
      exp_req = (m_phase == P_RUN) && !bus.flush &&
                (m_inflight.size() + m_buf.size() < DEPTH);
      check("imem_req", bus.imem_req, exp_req);
      check("pc_ena", bus.pc_ena, exp_req && bus.imem_ready);
      if (exp_req) check("imem_addr", bus.imem_addr, bus.pc_in);
      check("inst_valid", bus.inst_valid, m_buf.size() > 0);
      if (m_buf.size() > 0) begin
        check("inst_pc", bus.inst_pc, m_buf[0]);
        check("inst", bus.inst, mem_word(m_buf[0]));
      end else if (!m_seen) begin
        check("idle_inst_pc", bus.inst_pc, RESET_PC);
        check("idle_inst", bus.inst, 32'h0);
      end

      // Advance the model across the coming edge.
      if (bus.flush) begin
        n = (m_phase == P_DRAIN) ? m_drop : m_inflight.size();
        if (bus.imem_rvalid && n > 0) n--;
        m_inflight.delete();
        m_buf.delete();
        m_drop  = n;
        m_phase = (n > 0) ? P_DRAIN : P_RUN;
      end else begin
        case (m_phase)
          P_INIT:  m_phase = P_RUN;
          P_DRAIN: begin
            if (bus.imem_rvalid && m_drop > 0) m_drop--;
            if (m_drop == 0) m_phase = P_RUN;
          end
          default: begin
            if (m_buf.size() > 0 && bus.inst_ready) void'(m_buf.pop_front());
            if (bus.imem_rvalid && m_inflight.size() > 0) m_buf.push_back(m_inflight.pop_front());
            if (exp_req && bus.imem_ready) begin
              m_inflight.push_back(bus.pc_in);
              m_seen = 1'b1;
            end
          end
        endcase
      end

      // Environment: memory accepts what the DUT hands it and answers in order.
      if (bus.pc_ena) mem_q.push_back('{addr: bus.imem_addr, due: cyc + mem_lat});
      rv_nxt = 1'b0;
      rd_nxt = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
        r      = mem_q.pop_front();
        rv_nxt = 1'b1;
        rd_nxt = mem_word(r.addr);
      end
      if (bus.flush)       pc_nxt = flush_tgt;
      else if (bus.pc_ena) pc_nxt = bus.pc_in + 32'd4;
      else                 pc_nxt = bus.pc_in;
    end
    cyc++;
  end

  // Advance one cycle and apply environment-driven inputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.pc_in       = pc_nxt;
    bus.imem_rvalid = rv_nxt;
    bus.imem_rdata  = rd_nxt;
    bus.flush       = 1'b0;
  endtask

  // Hold reset for two cycles; returns inside the first cycle after release.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    int pops;
    int accepts;
    int waited;
    bit seen_req;
    bit found;
    rst             = 1'b1;
    bus.pc_in       = RESET_PC;
    bus.flush       = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("por_imem_req", bus.imem_req, 1'b0);
    check("por_inst_valid", bus.inst_valid, 1'b0);
    check("por_inst_pc", bus.inst_pc, RESET_PC);
    check("por_inst", bus.inst, 32'h0);

    // Reset release, 1-cycle memory, decode always ready.
    bus.imem_ready = 1'b1;
    bus.inst_ready = 1'b1;
    mem_lat        = 1;
    do_reset();
    #1 check("t1_init_req", bus.imem_req, 1'b0);
    tick(); #1;
    check("t1_first_req", bus.imem_req, 1'b1);
    check("t1_first_addr", bus.imem_addr, 32'h0040_0000);
    check("t1_first_pc_ena", bus.pc_ena, 1'b1);
    tick(); #1;
    check("t1_valid_not_yet", bus.inst_valid, 1'b0);
    tick(); #1;
    check("t1_valid", bus.inst_valid, 1'b1);
    check("t1_inst_pc", bus.inst_pc, 32'h0040_0000);
    check("t1_inst", bus.inst, mem_word(32'h0040_0000));
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.inst_valid && bus.inst_ready) pops++;
      tick(); #1;
    end
    check("t1_rate_2_per_3", pops, 8);

    // Decode stalled: exactly DEPTH accepts, then in-order pops.
    bus.inst_ready = 1'b0;
    do_reset();
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      #1 if (bus.pc_ena) accepts++;
      tick();
    end
    #1;
    check("t2_accepts", accepts, 2);
    check("t2_req_blocked", bus.imem_req, 1'b0);
    check("t2_pc_ena_low", bus.pc_ena, 1'b0);
    check("t2_head_valid", bus.inst_valid, 1'b1);
    check("t2_head_pc0", bus.inst_pc, 32'h0040_0000);
    bus.inst_ready = 1'b1;
    #1 check("t2_req_gated_on_pop", bus.imem_req, 1'b0);
    tick(); #1;
    check("t2_head_valid2", bus.inst_valid, 1'b1);
    check("t2_head_pc1", bus.inst_pc, 32'h0040_0004);
    check("t2_req_after_pop", bus.imem_req, 1'b1);
    check("t2_next_addr", bus.imem_addr, 32'h0040_0008);

    // Memory not ready: request held, address stable, nothing allocated.
    tick();
    bus.imem_ready = 1'b0;
    repeat (4) tick();
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_req_held", bus.imem_req, 1'b1);
      check("t3_pc_ena_low", bus.pc_ena, 1'b0);
      check("t3_addr_stable", bus.imem_addr, 32'h0040_000C);
      tick(); #1;
    end
    check("t3_nothing_buffered", bus.inst_valid, 1'b0);

    // Flush with two fetches in flight (3-cycle memory).
    bus.imem_ready = 1'b1;
    bus.inst_ready = 1'b0;
    mem_lat        = 3;
    do_reset();
    repeat (3) tick();
    #1 check("t4_full_req", bus.imem_req, 1'b0);
    bus.flush = 1'b1;
    flush_tgt = 32'h0040_0100;
    #1 check("t4_flush_req", bus.imem_req, 1'b0);
    seen_req = 1'b0;
    waited   = 0;
    for (int i = 0; i < 10 && !seen_req; i++) begin
      tick(); #1;
      waited++;
      check("t4_valid_low", bus.inst_valid, 1'b0);
      if (bus.imem_req) seen_req = 1'b1;
    end
    check("t4_req_seen", seen_req, 1'b1);
    check("t4_drain_cycles", waited, 3);
    check("t4_target_addr", bus.imem_addr, 32'h0040_0100);

    // Flush coinciding with the only outstanding response (2-cycle memory).
    mem_lat = 2;
    do_reset();
    tick();
    tick();
    bus.imem_ready = 1'b0;
    tick();
    bus.imem_ready = 1'b1;
    bus.flush      = 1'b1;
    flush_tgt      = 32'h0040_0200;
    #1 check("t5_flush_req", bus.imem_req, 1'b0);
    tick(); #1;
    check("t5_req_no_drain", bus.imem_req, 1'b1);
    check("t5_target_addr", bus.imem_addr, 32'h0040_0200);
    check("t5_dropped", bus.inst_valid, 1'b0);
    tick(); #1;
    check("t5_still_dropped", bus.inst_valid, 1'b0);

    // Reset asserted while draining, after words have been consumed.
    bus.inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (i >= 3 && m_inflight.size() > (bus.imem_rvalid ? 1 : 0)) found = 1'b1;
    end
    check("t6_inflight_found", found, 1'b1);
    bus.flush = 1'b1;
    flush_tgt = 32'h0040_0300;
    tick();
    rst = 1'b0;
    #1;
    check("t6_imem_req", bus.imem_req, 1'b0);
    check("t6_pc_ena", bus.pc_ena, 1'b0);
    check("t6_inst_valid", bus.inst_valid, 1'b0);
    check("t6_inst", bus.inst, 32'h0);
    check("t6_inst_pc", bus.inst_pc, RESET_PC);
    tick();
    tick();
    rst = 1'b1;
    #1 check("t6_init_req", bus.imem_req, 1'b0);
    tick(); #1;
    check("t6_restart_req", bus.imem_req, 1'b1);
    check("t6_restart_addr", bus.imem_addr, 32'h0040_0000);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run must end by itself.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
